fnd_scan_ctrl: RTL and testbench

Parametrised time-multiplexed 7-segment (FND) scan driver for the board display path of the pipelined RISC-V SoC. It replaces the fixed 8-digit/8-segment hookup with configurable digit count, scan rate and output polarity. It adds double-buffered value loading with tear-free frame swap, per-digit decimal points and leading-zero blanking. It sits between the processor's memory-mapped display register and the board `digit`/`fnd` pins.

---
 rtl/fnd_pkg.sv | 22 ++
 rtl/fnd_scan_ctrl_hex7seg.sv | 11 +
 rtl/fnd_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants and helpers for the 7-segment scan driver
package fnd_pkg;

    // Bit position of the decimal point inside the 8-bit segment bus.
    localparam int SEG_DP = 7;

    // Active-high segment patterns (bit0..6 = a..g) for hex digits 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Number of bits needed to hold values 0..n-1; never less than 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_hex7seg.sv
// hex7seg_decoder: combinational hex nibble to active-high 7-segment pattern
module hex7seg_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: time-multiplexed 7-segment scan driver with double-buffered, tear-free frame loading
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       load,
    input  logic [4*N_DIGITS-1:0]      value,
    input  logic [N_DIGITS-1:0]        dp,
    input  logic                       blank_lz,
    output logic [N_DIGITS-1:0]        digit,
    output logic [7:0]                 fnd,
    output logic [clog2(N_DIGITS)-1:0] scan_idx,
    output logic                       frame_done
);

    localparam int IW = clog2(N_DIGITS);
    localparam int PW = clog2(SCAN_DIV);
    localparam logic [IW-1:0]       LAST_IDX = IW'(N_DIGITS - 1);
    localparam logic [PW-1:0]       LAST_CNT = PW'(SCAN_DIV - 1);
    localparam logic [N_DIGITS-1:0] DIG_OFF  = {N_DIGITS{DIG_ACTIVE_LOW}};
    localparam logic [7:0]          SEG_OFF  = {8{SEG_ACTIVE_LOW}};

    logic [PW-1:0]         prescale;
    logic                  tick;
    logic                  wrap;
    logic [4*N_DIGITS-1:0] active_val;
    logic [N_DIGITS-1:0]   active_dp;
    logic [4*N_DIGITS-1:0] pend_val;
    logic [N_DIGITS-1:0]   pend_dp;
    logic                  pend_valid;
    logic [N_DIGITS-1:0]   lz;
    logic [3:0]            nibble;
    logic [6:0]            seg;
    logic [N_DIGITS-1:0]   digit_raw;
    logic [7:0]            fnd_raw;

    assign tick   = enable && (prescale == LAST_CNT);
    assign wrap   = tick && (scan_idx == LAST_IDX);
    assign nibble = active_val[{scan_idx, 2'b00} +: 4];

    hex7seg_decoder u_dec (
        .nibble (nibble),
        .seg    (seg)
    );

    // Prescaler and digit index; both freeze in place while scanning is disabled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prescale   <= '0;
            scan_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            if (enable)
                prescale <= tick ? '0 : prescale + 1'b1;
            if (tick)
                scan_idx <= wrap ? '0 : scan_idx + 1'b1;
            frame_done <= wrap;
        end
    end

    // Double buffer: loads land in pending and are promoted only at a frame wrap,
    // so a frame is never drawn from a mix of old and new data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            active_val <= '0;
            active_dp  <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp;
            end
            if (wrap && load) begin
                active_val <= value;
                active_dp  <= dp;
            end else if (wrap && pend_valid) begin
                active_val <= pend_val;
                active_dp  <= pend_dp;
            end
            pend_valid <= wrap ? 1'b0 : (load || pend_valid);
        end
    end

    // Leading-zero mask: digit i is a leading zero when it and every digit above it are 0.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz       = '0;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (active_val[4*i +: 4] == 4'h0);
            lz[i]    = zero_run;
        end
    end

    // Active-high digit select and segment image for the currently indexed digit.
    always_comb begin
        digit_raw           = '0;
        digit_raw[scan_idx] = 1'b1;
        fnd_raw             = '0;
        fnd_raw[6:0]        = (blank_lz && lz[scan_idx]) ? 7'h00 : seg;
        fnd_raw[SEG_DP]     = active_dp[scan_idx];
    end

    // Registered pin drivers with polarity applied; dark whenever scanning is disabled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            digit <= DIG_OFF;
            fnd   <= SEG_OFF;
        end else begin
            digit <= enable ? (digit_raw ^ DIG_OFF) : DIG_OFF;
            fnd   <= enable ? (fnd_raw ^ SEG_OFF) : SEG_OFF;
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: directed self-checking bench for the 4-digit, active-low scan driver
module tb_fnd_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  digit;
    logic [7:0]  fnd;
    logic [1:0]  scan_idx;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [7:0] EXP_1234 [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    localparam logic [7:0] EXP_ABCD [4] = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    localparam logic [7:0] EXP_0050 [4] = '{8'hC0, 8'h92, 8'hFF, 8'h7F};
    localparam logic [7:0] EXP_9876 [4] = '{8'h02, 8'hF8, 8'h00, 8'h90};

    fnd_scan_ctrl #(
        .N_DIGITS       (4),
        .SCAN_DIV       (4),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .blank_lz   (blank_lz),
        .digit      (digit),
        .fnd        (fnd),
        .scan_idx   (scan_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests += 4;
            if (digit !== 4'hF) begin n_fail++; $display("FAIL reset_digit got %b exp 1111", digit); end
            if (fnd !== 8'hFF) begin n_fail++; $display("FAIL reset_fnd got %h exp ff", fnd); end
            if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b exp 0", frame_done); end
            if (scan_idx !== 2'd0) begin n_fail++; $display("FAIL reset_scan_idx got %0d exp 0", scan_idx); end
        end
        reset = 1'b1;
    endtask

    task automatic test_load();
        bit ok;
        int idx;
        logic [3:0] exp_dig;
        value = 16'h1234;
        dp    = 4'b0000;
        load  = 1'b1;
        step();
        load  = 1'b0;
        wait_frame(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL load_first_wrap timeout got 0 exp 1"); end
        for (int c = 1; c <= 16; c++) begin
            step();
            idx     = (c - 1) / 4;
            exp_dig = ~(4'b0001 << idx);
            n_tests += 4;
            if (digit !== exp_dig) begin n_fail++; $display("FAIL load_digit c=%0d got %b exp %b", c, digit, exp_dig); end
            if (fnd !== EXP_1234[idx]) begin n_fail++; $display("FAIL load_fnd c=%0d got %h exp %h", c, fnd, EXP_1234[idx]); end
            if (scan_idx !== 2'((c / 4) % 4)) begin n_fail++; $display("FAIL load_scan_idx c=%0d got %0d exp %0d", c, scan_idx, (c / 4) % 4); end
            if (frame_done !== (c == 16)) begin n_fail++; $display("FAIL load_frame_done c=%0d got %b exp %b", c, frame_done, c == 16); end
        end
    endtask

    task automatic test_midframe_load();
        int idx;
        logic [7:0] exp_fnd;
        for (int c = 1; c <= 4; c++) step();
        n_tests++;
        if (scan_idx !== 2'd1) begin n_fail++; $display("FAIL mid_scan_idx got %0d exp 1", scan_idx); end
        value = 16'hABCD;
        load  = 1'b1;
        for (int c = 5; c <= 32; c++) begin
            step();
            load    = 1'b0;
            idx     = (c <= 16) ? (c - 1) / 4 : (c - 17) / 4;
            exp_fnd = (c <= 16) ? EXP_1234[idx] : EXP_ABCD[idx];
            n_tests += 2;
            if (fnd !== exp_fnd) begin n_fail++; $display("FAIL mid_fnd c=%0d got %h exp %h", c, fnd, exp_fnd); end
            if (frame_done !== (c == 16 || c == 32)) begin n_fail++; $display("FAIL mid_frame_done c=%0d got %b exp %b", c, frame_done, c == 16 || c == 32); end
        end
    endtask

    task automatic test_blank_lz();
        bit ok;
        int idx;
        logic [3:0] exp_dig;
        blank_lz = 1'b1;
        value    = 16'h0050;
        dp       = 4'b1000;
        load     = 1'b1;
        step();
        load     = 1'b0;
        wait_frame(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL blank_wrap timeout got 0 exp 1"); end
        for (int c = 1; c <= 16; c++) begin
            step();
            idx     = (c - 1) / 4;
            exp_dig = ~(4'b0001 << idx);
            n_tests += 2;
            if (digit !== exp_dig) begin n_fail++; $display("FAIL blank_digit c=%0d got %b exp %b", c, digit, exp_dig); end
            if (fnd !== EXP_0050[idx]) begin n_fail++; $display("FAIL blank_fnd c=%0d got %h exp %h", c, fnd, EXP_0050[idx]); end
        end
    endtask

    task automatic test_enable_pause();
        step();
        step();
        n_tests++;
        if (scan_idx !== 2'd0) begin n_fail++; $display("FAIL pause_pre_idx got %0d exp 0", scan_idx); end
        enable = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_tests += 4;
            if (digit !== 4'hF) begin n_fail++; $display("FAIL pause_digit i=%0d got %b exp 1111", i, digit); end
            if (fnd !== 8'hFF) begin n_fail++; $display("FAIL pause_fnd i=%0d got %h exp ff", i, fnd); end
            if (scan_idx !== 2'd0) begin n_fail++; $display("FAIL pause_scan_idx i=%0d got %0d exp 0", i, scan_idx); end
            if (frame_done !== 1'b0) begin n_fail++; $display("FAIL pause_frame_done i=%0d got %b exp 0", i, frame_done); end
        end
        enable = 1'b1;
        step();
        n_tests += 3;
        if (scan_idx !== 2'd0) begin n_fail++; $display("FAIL resume_idx0 got %0d exp 0", scan_idx); end
        if (digit !== 4'hE) begin n_fail++; $display("FAIL resume_digit0 got %b exp 1110", digit); end
        if (fnd !== 8'hC0) begin n_fail++; $display("FAIL resume_fnd0 got %h exp c0", fnd); end
        step();
        n_tests++;
        if (scan_idx !== 2'd1) begin n_fail++; $display("FAIL resume_idx1 got %0d exp 1", scan_idx); end
        step();
        n_tests += 2;
        if (digit !== 4'hD) begin n_fail++; $display("FAIL resume_digit1 got %b exp 1101", digit); end
        if (fnd !== 8'h92) begin n_fail++; $display("FAIL resume_fnd1 got %h exp 92", fnd); end
    endtask

    task automatic test_wrap_load_and_reset();
        bit ok;
        int idx;
        wait_frame(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL wrapload_sync timeout got 0 exp 1"); end
        blank_lz = 1'b0;
        for (int c = 1; c <= 15; c++) step();
        value = 16'h9876;
        dp    = 4'b0101;
        load  = 1'b1;
        step();
        load  = 1'b0;
        n_tests++;
        if (frame_done !== 1'b1) begin n_fail++; $display("FAIL wrapload_frame_done got %b exp 1", frame_done); end
        for (int c = 1; c <= 9; c++) begin
            step();
            idx = (c - 1) / 4;
            n_tests++;
            if (fnd !== EXP_9876[idx]) begin n_fail++; $display("FAIL wrapload_fnd c=%0d got %h exp %h", c, fnd, EXP_9876[idx]); end
        end
        n_tests++;
        if (scan_idx !== 2'd2) begin n_fail++; $display("FAIL wrapload_idx got %0d exp 2", scan_idx); end
        value = 16'h1111;
        dp    = 4'b0000;
        load  = 1'b1;
        step();
        load  = 1'b0;
        n_tests++;
        if (fnd !== 8'h00) begin n_fail++; $display("FAIL preload_fnd got %h exp 00", fnd); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests += 4;
            if (digit !== 4'hF) begin n_fail++; $display("FAIL midreset_digit got %b exp 1111", digit); end
            if (fnd !== 8'hFF) begin n_fail++; $display("FAIL midreset_fnd got %h exp ff", fnd); end
            if (scan_idx !== 2'd0) begin n_fail++; $display("FAIL midreset_idx got %0d exp 0", scan_idx); end
            if (frame_done !== 1'b0) begin n_fail++; $display("FAIL midreset_frame_done got %b exp 0", frame_done); end
        end
        reset = 1'b1;
        wait_frame(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL postreset_wrap timeout got 0 exp 1"); end
        for (int c = 1; c <= 16; c++) begin
            step();
            n_tests++;
            if (fnd !== 8'hC0) begin n_fail++; $display("FAIL postreset_fnd c=%0d got %h exp c0", c, fnd); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_midframe_load();
        test_blank_lz();
        test_enable_pause();
        test_wrap_load_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running exp finished");
        $fatal(1);
    end

endmodule
